// File: rtl/cayde_fetch.sv
// Instruction fetch unit: one outstanding memory request feeding a 2-entry {pc, instr} buffer.
// Build option CAYDE_FETCH_MISALIGN_EN: a misaligned redirect sets sticky fetch_err and halts fetching.
module cayde_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fetch_err
);
  localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:2], 2'b00};
  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_reg;
  logic        req_reg;
  logic [31:0] addr_reg;
  logic [31:0] pc_reg;
  logic        discard_reg;
  logic        err_reg;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;

  logic [31:0] redirect_target;
  logic [31:0] issue_addr;
  logic        misalign;
  logic        err_next;
  logic        push;
  logic        pop;
  logic        can_issue;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign issue_addr      = redirect_valid ? redirect_target : pc_reg;

`ifdef CAYDE_FETCH_MISALIGN_EN
  assign misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_err = err_reg;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign misalign  = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign err_next = err_reg | misalign;

  // A response is buffered only if nothing invalidated it; redirect beats push and pop.
  assign push = (state_reg == WAIT) && imem_rvalid && !discard_reg && !redirect_valid;
  assign pop  = (count_reg != 2'd0) && instr_ready && !redirect_valid;

  always_comb begin
    count_next = count_reg;
    if (redirect_valid) begin
      count_next = 2'd0;
    end else if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (pop && !push) begin
      count_next = count_reg - 2'd1;
    end
  end

  // A new request needs a slot that is free after this cycle's push/pop/flush settle.
  assign can_issue = fetch_enable && !err_next && (count_next < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      req_reg     <= 1'b0;
      addr_reg    <= BOOT_PC;
      pc_reg      <= BOOT_PC;
      discard_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= err_next;
      if (redirect_valid) begin
        pc_reg <= redirect_target;
      end
      case (state_reg)
        IDLE: begin
          if (can_issue) begin
            state_reg <= REQ;
            req_reg   <= 1'b1;
            addr_reg  <= issue_addr;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            state_reg   <= WAIT;
            req_reg     <= 1'b0;
            if (!discard_reg && !redirect_valid) begin
              pc_reg <= pc_reg + 32'd4;
            end
            discard_reg <= discard_reg | redirect_valid;
          end else if (redirect_valid) begin
            // The old address stays on the bus until granted; its data is dropped later.
            discard_reg <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            discard_reg <= 1'b0;
            if (can_issue) begin
              state_reg <= REQ;
              req_reg   <= 1'b1;
              addr_reg  <= issue_addr;
            end else begin
              state_reg <= IDLE;
            end
          end else if (redirect_valid) begin
            discard_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      count_reg <= count_next;
      if (redirect_valid) begin
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr_reg]    <= addr_reg;
          instr_mem[wr_ptr_reg] <= imem_rdata;
          wr_ptr_reg            <= ~wr_ptr_reg;
        end
        if (pop) begin
          rd_ptr_reg <= ~rd_ptr_reg;
        end
      end
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = addr_reg;
  assign instr_valid = (count_reg != 2'd0);
  assign instr_out   = instr_mem[rd_ptr_reg];
  assign instr_pc    = pc_mem[rd_ptr_reg];

endmodule

// File: tb/tb_cayde_fetch.sv
// Randomized bench for cayde_fetch: memory responder plus an in-order instruction-stream model.
module tb_cayde_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_enable = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fetch_err;

  cayde_fetch #(.BOOT_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_enable(fetch_enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int gnt_pct = 100;
  int ready_pct = 100;
  int lat_min = 0;
  int lat_max = 0;
  bit stale_rv = 1'b0;
  bit pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int pend_wait = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] popq[$];
  logic [31:0] instq[$];
  int total_pops = 0;

  // Memory contents: every word is derived from its own address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] popq_at(input int i);
    if (i < popq.size()) return popq[i];
    return 32'hBAD0_BAD1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, want);
    end
  endtask

  // One clock: drive memory/decoder inputs, take the edge, then check everything it implied.
  task automatic cycle();
    logic        req_s, valid_s, popped;
    logic [31:0] addr_s, out_s, pc_s;
    imem_rvalid = pend && (pend_wait == 0);
    imem_rdata  = imem_rvalid ? instr_of(pend_addr) : $urandom;
    if (stale_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      stale_rv    = 1'b0;
    end
    imem_gnt    = imem_req && (int'($urandom_range(99)) < gnt_pct);
    instr_ready = (int'($urandom_range(99)) < ready_pct);
    req_s   = imem_req;
    addr_s  = imem_addr;
    valid_s = instr_valid;
    out_s   = instr_out;
    pc_s    = instr_pc;
    @(posedge clk);
    #1;
    popped = valid_s && instr_ready && !redirect_valid;
    if (popped) begin
      $display("pop pc=%h instr=%h", pc_s, out_s);
      chk("pop_pc", pc_s, exp_pc);
      chk("pop_instr", out_s, instr_of(exp_pc));
      popq.push_back(pc_s);
      instq.push_back(out_s);
      total_pops++;
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
      chk_bit("flush_valid", instr_valid, 1'b0);
    end
    if (req_s && !imem_gnt) begin
      chk_bit("req_hold", imem_req, 1'b1);
      chk("addr_hold", imem_addr, addr_s);
    end
    if (!req_s && imem_req) chk_bit("issue_enable", fetch_enable, 1'b1);
    if (imem_rvalid) pend = 1'b0;
    if (req_s && imem_gnt) begin
      pend      = 1'b1;
      pend_addr = addr_s;
      pend_wait = int'($urandom_range(lat_max, lat_min));
    end else if (pend && pend_wait > 0) begin
      pend_wait--;
    end
    if (imem_req) begin
      chk_bit("one_outstanding", pend, 1'b0);
      chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    end
`ifndef CAYDE_FETCH_MISALIGN_EN
    chk_bit("err_tied", fetch_err, 1'b0);
`endif
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    #2;
    chk_bit("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk_bit("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk_bit("rst_err", fetch_err, 1'b0);
    @(posedge clk);
    #1;
    pend   = 1'b0;
    exp_pc = 32'h0;
    popq.delete();
    instq.delete();
    rst_n    = 1'b1;
    stale_rv = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (popq.size() < n && i < budget) begin
      cycle();
      i++;
    end
    chk_bit(name, popq.size() >= n, 1'b1);
  endtask

  initial begin
    int i;
    int start;
    logic [31:0] addr0;
    logic [31:0] tgt;
    #1;
    fetch_enable = 1'b1;
    do_reset();

    // Boot: immediate grant, single-cycle latency, decoder always ready.
    cycle();
    chk_bit("boot_req", imem_req, 1'b1);
    chk("boot_addr", imem_addr, 32'h0);
    wait_pops(3, 50, "boot_stream");
    chk("seq_pc0", popq_at(0), 32'h0);
    chk("seq_pc1", popq_at(1), 32'h4);
    chk("seq_pc2", popq_at(2), 32'h8);
    chk("seq_instr0", (instq.size() > 0) ? instq[0] : 32'hBAD0_BAD1, 32'hC0DE_0000);

    // Decoder stalls: buffer fills to two entries and requests stop.
    ready_pct = 0;
    repeat (10) cycle();
    chk_bit("full_req_low", imem_req, 1'b0);
    chk_bit("full_valid", instr_valid, 1'b1);
    chk_bit("full_no_pend", pend, 1'b0);
    popq.delete();
    gnt_pct   = 0;
    ready_pct = 100;
    repeat (5) cycle();
    chk("buffered_count", 32'(popq.size()), 32'd2);

    // Grant withheld: request and address held.
    chk_bit("stall_req0", imem_req, 1'b1);
    addr0 = imem_addr;
    chk("stall_addr_next", addr0, exp_pc);
    repeat (5) begin
      cycle();
      chk_bit("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, addr0);
    end
    gnt_pct = 100;
    wait_pops(4, 50, "resume_stream");

    // Redirect while waiting on the response for address 8.
    lat_min = 3;
    lat_max = 3;
    do_reset();
    i = 0;
    while (!(pend && pend_addr == 32'h8) && i < 60) begin
      cycle();
      i++;
    end
    chk_bit("wait8_seen", pend && (pend_addr == 32'h8), 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    popq.delete();
    cycle();
    wait_pops(1, 60, "redirect_stream");
    chk("redirect_first", popq_at(0), 32'h100);

    // Redirect to the top of the address space: fetch wraps to zero.
    lat_min = 0;
    lat_max = 0;
    ready_pct = 0;
    repeat (12) cycle();
    ready_pct      = 100;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    popq.delete();
    cycle();
    wait_pops(2, 60, "wrap_stream");
    chk("wrap_pc0", popq_at(0), 32'hFFFF_FFFC);
    chk("wrap_pc1", popq_at(1), 32'h0);

    // Misaligned redirect.
    ready_pct = 0;
    repeat (12) cycle();
    ready_pct      = 100;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    popq.delete();
    cycle();
`ifdef CAYDE_FETCH_MISALIGN_EN
    chk_bit("misalign_err", fetch_err, 1'b1);
    repeat (20) begin
      cycle();
      chk_bit("halt_req", imem_req, 1'b0);
      chk_bit("halt_valid", instr_valid, 1'b0);
      chk_bit("err_sticky", fetch_err, 1'b1);
    end
`else
    i = 0;
    while (!imem_req && i < 20) begin
      cycle();
      i++;
    end
    chk("misalign_addr", imem_addr, 32'h100);
    wait_pops(1, 60, "misalign_stream");
    chk("misalign_first", popq_at(0), 32'h100);
`endif

    // Random traffic: stalls, latencies, enable toggling and redirects.
    do_reset();
    gnt_pct   = 60;
    ready_pct = 70;
    lat_min   = 0;
    lat_max   = 4;
    start     = total_pops;
    for (int k = 0; k < 2000; k++) begin
      fetch_enable = ($urandom_range(9) != 0);
      if ($urandom_range(39) == 0) begin
        tgt = $urandom;
        if ($urandom_range(3) == 0) tgt[31:4] = 28'hFFF_FFFF;
`ifdef CAYDE_FETCH_MISALIGN_EN
        tgt[1:0] = 2'b00;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
      end
      cycle();
    end
    chk_bit("random_progress", (total_pops - start) > 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cayde_fetch.md
CAYDE_FETCH -- requirements
Module: cayde_fetch

Interface
REQ-001 SHALL provide parameter BOOT_ADDR, default 32'h0000_0000, meaning first fetch address after reset (bits [1:0] ignored, treated as 00).
REQ-002 SHALL provide port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port fetch_enable  input  1  permits new memory requests when high.
REQ-005 SHALL provide port imem_req  output  1  instruction memory request.
REQ-006 SHALL provide port imem_addr  output  32  word-aligned request address.
REQ-007 SHALL provide port imem_gnt  input  1  memory accepts request this cycle.
REQ-008 SHALL provide port imem_rvalid  input  1  read data valid.
REQ-009 SHALL provide port imem_rdata  input  32  instruction word.
REQ-010 SHALL provide port redirect_valid  input  1  pipeline flush/jump request.
REQ-011 SHALL provide port redirect_pc  input  32  new fetch address.
REQ-012 SHALL provide port instr_valid  output  1  instruction available to decoder.
REQ-013 SHALL provide port instr_ready  input  1  decoder consumes instruction.
REQ-014 SHALL provide port instr_out  output  32  instruction word to decoder.
REQ-015 SHALL provide port instr_pc  output  32  address of instr_out.
REQ-016 SHALL provide port fetch_err  output  1  sticky misaligned-redirect flag.

Function
REQ-017 SHALL implement FSM IDLE / REQ / WAIT: IDLE->REQ when fetch_enable and a buffer slot is free; REQ->WAIT on imem_gnt; WAIT->REQ on imem_rvalid if a slot is still free and fetch_enable, else WAIT->IDLE.
REQ-018 SHALL hold imem_req high and imem_addr stable in REQ until imem_gnt; at most one request outstanding.
REQ-019 SHALL increment fetch PC by 4 on each grant, 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 SHALL buffer responses in a 2-entry FIFO storing {pc, instr}; a request is issued only if occupancy plus outstanding < 2.
REQ-021 SHALL drive instr_valid/instr_out/instr_pc from the FIFO head; pop on instr_valid && instr_ready.
REQ-022 SHALL allow push and pop in the same cycle at any occupancy, including full (occupancy unchanged).
REQ-023 SHALL present an instruction no earlier than the cycle after its imem_rvalid (registered path).
REQ-024 SHALL, on redirect_valid, flush the FIFO (instr_valid low next cycle) and load fetch PC with {redirect_pc[31:2],2'b00}.
REQ-025 SHALL, if a request is outstanding or granted in the redirect cycle, discard its response; a request in REQ without grant completes with the old address and is discarded.
REQ-026 SHALL give redirect priority over same-cycle pop and push.
REQ-027 SHALL stop issuing when fetch_enable is low but complete any outstanding transaction and keep buffered instructions.

Reset
REQ-028 SHALL, while rst_n low, asynchronously force: FSM IDLE, fetch PC = BOOT_ADDR, FIFO empty, discard flag 0, imem_req 0, imem_addr BOOT_ADDR, instr_valid 0, instr_out 0, instr_pc 0, fetch_err 0.
REQ-029 SHALL assert imem_req in the first cycle after rst_n deasserts when fetch_enable is high.
REQ-030 SHALL, on reset mid-transaction, ignore any later imem_rvalid for the abandoned request.

Configuration
REQ-031 SHALL, with CAYDE_FETCH_MISALIGN_EN defined, treat redirect_pc[1:0] != 00 as error: set fetch_err (sticky until reset), flush FIFO, stop issuing requests.
REQ-032 SHALL, without CAYDE_FETCH_MISALIGN_EN, silently clear redirect_pc[1:0] and tie fetch_err to 0.

Verification
REQ-033 SHALL cover: reset release, BOOT_ADDR=0, gnt immediate, rvalid next cycle, ready=1 -> addresses 0,4,8 in order, instr_pc matches each instr_out.
REQ-034 SHALL cover: instr_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req low, no data lost after ready=1.
REQ-035 SHALL cover: redirect to 32'h0000_0100 while WAIT for address 8 -> response for 8 dropped, next instr_pc = 32'h100.
REQ-036 SHALL cover: imem_gnt low for 5 cycles -> imem_addr stable throughout, imem_req held high.
REQ-037 SHALL cover: redirect_pc = 32'h0000_0102 -> with macro fetch_err=1 and no further imem_req; without macro next fetch address 32'h100.
REQ-038 SHALL cover: redirect to 32'hFFFF_FFFC -> consecutive fetches at 32'hFFFF_FFFC then 32'h0000_0000.
